obi_mem_responder: RTL and testbench

Single-port OBI memory responder that serves the core's instruction or data request/grant/rvalid interface. It is the target end of the handshake the CPU drives.
- Accepts one address phase per grant and returns exactly one response per grant on the following cycle.
- Supports byte-enable writes, a configurable number of grant wait states and an address window check.
- Instantiated behind the bus as local RAM, and standalone in benches as a core-facing memory model.

---
 rtl/obi_mem_responder_if.sv | 22 ++
 rtl/obi_mem_responder.sv | 70 +++++++
 tb/tb_obi_mem_responder.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obi_mem_responder_if.sv
// OBI request/grant/rvalid bundle between a core-side initiator and a memory responder.
interface obi_mem_responder_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        oob;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, oob
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, oob
    );
endinterface

// File: rtl/obi_mem_responder.sv
// Single-port OBI memory responder: byte-enable word RAM with programmable grant
// wait states, an address window check and a one-cycle registered response.
module obi_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 2048,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic               clk,
    input logic               rst,
    obi_mem_responder_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);

    typedef enum logic {
        IDLE,
        RESP
    } resp_state_t;

    resp_state_t      state;
    logic [2:0]       cnt;
    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      off;
    logic [31:0]      rdata_q;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             hs;
    logic             oob_q;

    // Offset arithmetic wraps, so addresses below the base land far above the span.
    assign off      = bus.addr - BASE_ADDR;
    assign in_range = off < SPAN;
    assign idx      = off[IDX_W+1:2];

    assign bus.gnt = bus.req && !rst && (cnt == 3'(WAIT_STATES));
    assign hs      = bus.req && bus.gnt;

    assign bus.rvalid = (state == RESP);
    assign bus.rdata  = rdata_q;
    assign bus.oob    = oob_q;

    // Storage is never reset; hs is already blocked while rst is high.
    always_ff @(posedge clk) begin
        if (hs && bus.we && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.be[i]) begin
                    mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            rdata_q <= 32'h0000_0000;
            oob_q   <= 1'b0;
        end else begin
            cnt   <= (bus.req && !bus.gnt) ? cnt + 3'd1 : 3'd0;
            oob_q <= hs && !in_range;
            state <= hs ? RESP : IDLE;
            if (hs) begin
                rdata_q <= (in_range && !bus.we) ? mem[idx] : 32'h0000_0000;
            end
        end
    end

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: a zero-wait 2048-word RAM at 0 and a three-wait
// 16-word window at 0x1000, both compared against a behavioural memory model.
module tb_obi_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] mem0 [0:2047];
    logic [31:0] mem1 [0:15];

    obi_mem_responder_if b0 ();
    obi_mem_responder_if b1 ();

    obi_mem_responder #(.DEPTH_WORDS(2048), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst), .bus(b0)
    );

    obi_mem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(3)) u1 (
        .clk(clk), .rst(rst), .bus(b1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] be_v);
        logic [31:0] mask;
        mask = {{8{be_v[3]}}, {8{be_v[2]}}, {8{be_v[1]}}, {8{be_v[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // Apply one granted access to the model memory; result is {oob, rdata}.
    function automatic logic [32:0] model0(input logic w, input logic [3:0] be_v,
                                           input logic [31:0] a, input logic [31:0] d);
        if (a >= 32'h0000_2000) return {1'b1, 32'h0};
        if (w) begin
            mem0[a[12:2]] = merge_bytes(mem0[a[12:2]], d, be_v);
            return {1'b0, 32'h0};
        end
        return {1'b0, mem0[a[12:2]]};
    endfunction

    function automatic logic [32:0] model1(input logic w, input logic [3:0] be_v,
                                           input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        off = a - 32'h0000_1000;
        if (off >= 32'd64) return {1'b1, 32'h0};
        if (w) begin
            mem1[off[5:2]] = merge_bytes(mem1[off[5:2]], d, be_v);
            return {1'b0, 32'h0};
        end
        return {1'b0, mem1[off[5:2]]};
    endfunction

    task automatic drive0(input logic r, input logic w, input logic [3:0] be_v,
                          input logic [31:0] a, input logic [31:0] d);
        b0.req = r; b0.we = w; b0.be = be_v; b0.addr = a; b0.wdata = d;
    endtask

    task automatic drive1(input logic r, input logic w, input logic [3:0] be_v,
                          input logic [31:0] a, input logic [31:0] d);
        b1.req = r; b1.we = w; b1.be = be_v; b1.addr = a; b1.wdata = d;
    endtask

    // One full transaction on the wait-state instance; returns at the response cycle.
    task automatic xfer1(input logic w, input logic [3:0] be_v, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        drive1(1'b1, w, be_v, a, d);
        repeat (4) @(negedge clk);
        drive1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset;
        logic [32:0] resp;
        rst = 1'b1;
        drive0(1'b1, 1'b1, 4'hF, 32'h0, 32'h0BAD_0BAD);
        drive1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (b0.gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_gnt: got %b expected 0", b0.gnt); end
            n_checks++;
            if ({b0.rvalid, b0.oob} !== 2'b00) begin
                n_fail++; $display("[TB] FAIL rst_rvalid_oob: got %b expected 00", {b0.rvalid, b0.oob});
            end
            n_checks++;
            if (b0.rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_rdata: got %h expected 0", b0.rdata); end
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (b0.gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_first_gnt: got %b expected 1", b0.gnt); end
        resp = model0(1'b1, 4'hF, 32'h0, 32'h0BAD_0BAD);
        @(negedge clk);
        n_checks++;
        if (b0.rvalid !== 1'b1 || b0.rdata !== resp[31:0]) begin
            n_fail++; $display("[TB] FAIL rst_first_resp: got rvalid=%b rdata=%h expected 1 %h", b0.rvalid, b0.rdata, resp[31:0]);
        end
        drive0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_write_read;
        logic [32:0] resp;
        @(negedge clk);
        drive0(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        resp = model0(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        #1;
        n_checks++;
        if (b0.gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_gnt: got %b expected 1", b0.gnt); end
        @(negedge clk);
        n_checks++;
        if (b0.rvalid !== 1'b1 || b0.rdata !== resp[31:0] || b0.oob !== 1'b0) begin
            n_fail++; $display("[TB] FAIL wr_resp: got rvalid=%b rdata=%h oob=%b expected 1 %h 0", b0.rvalid, b0.rdata, b0.oob, resp[31:0]);
        end
        drive0(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        resp = model0(1'b0, 4'hF, 32'h10, 32'h0);
        #1;
        n_checks++;
        if (b0.gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_gnt: got %b expected 1", b0.gnt); end
        @(negedge clk);
        n_checks++;
        if (b0.rvalid !== 1'b1 || b0.rdata !== resp[31:0]) begin
            n_fail++; $display("[TB] FAIL rd_resp: got rvalid=%b rdata=%h expected 1 %h", b0.rvalid, b0.rdata, resp[31:0]);
        end
        drive0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (b0.rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_rvalid_drop: got %b expected 0", b0.rvalid); end
    endtask

    task automatic test_byte_enables;
        logic        t_we [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0]  t_be [6] = '{4'hF, 4'b0101, 4'h0, 4'h0, 4'b1010, 4'h3};
        logic [31:0] t_a  [6] = '{32'h20, 32'h20, 32'h22, 32'h20, 32'h21, 32'h23};
        logic [31:0] t_d  [6] = '{32'h1122_3344, 32'hAABB_CCDD, 32'h0, 32'hFFFF_FFFF, 32'h00EE_00FF, 32'h0};
        logic [32:0] q [$];
        logic [32:0] want;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                want = q.pop_front();
                n_checks++;
                if (b0.rvalid !== 1'b1 || b0.rdata !== want[31:0]) begin
                    n_fail++; $display("[TB] FAIL be_resp%0d: got rvalid=%b rdata=%h expected 1 %h", i - 1, b0.rvalid, b0.rdata, want[31:0]);
                end
            end
            if (i < 6) begin
                drive0(1'b1, t_we[i], t_be[i], t_a[i], t_d[i]);
                q.push_back(model0(t_we[i], t_be[i], t_a[i], t_d[i]));
                #1;
                n_checks++;
                if (b0.gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL be_gnt%0d: got %b expected 1", i, b0.gnt); end
            end else begin
                drive0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [32:0] q [$];
        logic [32:0] want;
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        int          pulses = 0;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i > 0) begin
                want = q.pop_front();
                if (b0.rvalid === 1'b1) pulses++;
                n_checks++;
                if (b0.rvalid !== 1'b1 || b0.rdata !== want[31:0]) begin
                    n_fail++; $display("[TB] FAIL b2b_resp%0d: got rvalid=%b rdata=%h expected 1 %h", i - 1, b0.rvalid, b0.rdata, want[31:0]);
                end
            end
            if (i < 16) begin
                w = (i < 8);
                a = 32'((i % 8) * 4);
                d = $urandom;
                drive0(1'b1, w, 4'hF, a, d);
                q.push_back(model0(w, 4'hF, a, d));
                #1;
                n_checks++;
                if (b0.gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_gnt%0d: got %b expected 1", i, b0.gnt); end
            end else begin
                drive0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            end
        end
        @(negedge clk);
        n_checks++;
        if (b0.rvalid !== 1'b0 || pulses != 16) begin
            n_fail++; $display("[TB] FAIL b2b_pulses: got %0d pulses, rvalid=%b expected 16, 0", pulses, b0.rvalid);
        end
    endtask

    task automatic test_reset_mid;
        logic [32:0] resp;
        @(negedge clk);
        drive0(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        resp = model0(1'b0, 4'hF, 32'h10, 32'h0);
        @(negedge clk);
        n_checks++;
        if (b0.rvalid !== 1'b1 || b0.rdata !== resp[31:0]) begin
            n_fail++; $display("[TB] FAIL mid_pre: got rvalid=%b rdata=%h expected 1 %h", b0.rvalid, b0.rdata, resp[31:0]);
        end
        rst = 1'b1;
        drive0(1'b1, 1'b1, 4'hF, 32'h10, ~resp[31:0]);
        #1;
        n_checks++;
        if (b0.gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_gnt: got %b expected 0", b0.gnt); end
        @(negedge clk);
        n_checks++;
        if (b0.rvalid !== 1'b0 || b0.rdata !== 32'h0) begin
            n_fail++; $display("[TB] FAIL mid_cancel: got rvalid=%b rdata=%h expected 0 0", b0.rvalid, b0.rdata);
        end
        rst = 1'b0;
        drive0(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        resp = model0(1'b0, 4'hF, 32'h10, 32'h0);
        @(negedge clk);
        n_checks++;
        if (b0.rvalid !== 1'b1 || b0.rdata !== resp[31:0]) begin
            n_fail++; $display("[TB] FAIL mid_nowrite: got rvalid=%b rdata=%h expected 1 %h", b0.rvalid, b0.rdata, resp[31:0]);
        end
        drive0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_random0;
        logic        pend = 1'b0;
        logic [32:0] want = '0;
        logic        r;
        logic        w;
        logic [3:0]  be_v;
        logic [31:0] a;
        logic [31:0] d;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            d = $urandom;
            drive0(1'b1, 1'b1, 4'hF, 32'(k * 4), d);
            void'(model0(1'b1, 4'hF, 32'(k * 4), d));
        end
        @(negedge clk);
        drive0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i <= 300; i++) begin
            @(negedge clk);
            n_checks++;
            if (b0.rvalid !== pend) begin n_fail++; $display("[TB] FAIL rnd0_rvalid%0d: got %b expected %b", i, b0.rvalid, pend); end
            if (pend) begin
                n_checks++;
                if (b0.rdata !== want[31:0] || b0.oob !== want[32]) begin
                    n_fail++; $display("[TB] FAIL rnd0_resp%0d: got rdata=%h oob=%b expected %h %b", i, b0.rdata, b0.oob, want[31:0], want[32]);
                end
            end
            r = (i < 300) && ($urandom_range(0, 3) != 0);
            w = 1'($urandom_range(0, 1));
            be_v = 4'($urandom);
            d = $urandom;
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_2000;
            else a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
            drive0(r, w, be_v, a, d);
            pend = r;
            if (r) want = model0(w, be_v, a, d);
            #1;
            n_checks++;
            if (b0.gnt !== r) begin n_fail++; $display("[TB] FAIL rnd0_gnt%0d: got %b expected %b", i, b0.gnt, r); end
        end
    endtask

    task automatic test_wait_states;
        logic [32:0] want;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            drive1(1'b1, t == 0, 4'hF, 32'h1004, 32'hCAFE_F00D);
            for (int c = 1; c <= 4; c++) begin
                if (c > 1) begin
                    @(negedge clk);
                    n_checks++;
                    if (b1.rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL ws_early_rvalid%0d: got %b expected 0", c, b1.rvalid); end
                end
                #1;
                n_checks++;
                if (b1.gnt !== (c == 4)) begin n_fail++; $display("[TB] FAIL ws_gnt_cycle%0d: got %b expected %b", c, b1.gnt, c == 4); end
            end
            want = model1(t == 0, 4'hF, 32'h1004, 32'hCAFE_F00D);
            @(negedge clk);
            n_checks++;
            if (b1.rvalid !== 1'b1 || b1.rdata !== want[31:0]) begin
                n_fail++; $display("[TB] FAIL ws_resp%0d: got rvalid=%b rdata=%h expected 1 %h", t, b1.rvalid, b1.rdata, want[31:0]);
            end
            drive1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            @(negedge clk);
            n_checks++;
            if (b1.rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL ws_pulse%0d: got %b expected 0", t, b1.rvalid); end
        end
    endtask

    task automatic test_abort;
        logic [32:0] want;
        xfer1(1'b1, 4'hF, 32'h100C, 32'h5A5A_A5A5);
        void'(model1(1'b1, 4'hF, 32'h100C, 32'h5A5A_A5A5));
        @(negedge clk);
        drive1(1'b1, 1'b1, 4'hF, 32'h100C, 32'hFFFF_0000);
        for (int c = 1; c <= 2; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            n_checks++;
            if (b1.gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_gnt%0d: got %b expected 0", c, b1.gnt); end
        end
        @(negedge clk);
        drive1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (b1.rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_rvalid%0d: got %b expected 0", c, b1.rvalid); end
        end
        n_checks++;
        if (u1.cnt !== 3'd0) begin n_fail++; $display("[TB] FAIL abort_cnt: got %0d expected 0", u1.cnt); end
        xfer1(1'b0, 4'hF, 32'h100C, 32'h0);
        want = model1(1'b0, 4'hF, 32'h100C, 32'h0);
        n_checks++;
        if (b1.rvalid !== 1'b1 || b1.rdata !== want[31:0]) begin
            n_fail++; $display("[TB] FAIL abort_nowrite: got rvalid=%b rdata=%h expected 1 %h", b1.rvalid, b1.rdata, want[31:0]);
        end
    endtask

    task automatic test_out_of_range;
        logic        t_we [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] t_a  [7] = '{32'h1000, 32'h1040, 32'h1000, 32'h0FFC, 32'h103C, 32'h103C, 32'hFFFF_F000};
        logic [31:0] t_d  [7] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0F0F_1E1E, 32'h0, 32'h0};
        logic [32:0] want;
        for (int i = 0; i < 7; i++) begin
            xfer1(t_we[i], 4'hF, t_a[i], t_d[i]);
            want = model1(t_we[i], 4'hF, t_a[i], t_d[i]);
            n_checks++;
            if (b1.rvalid !== 1'b1 || b1.rdata !== want[31:0] || b1.oob !== want[32]) begin
                n_fail++; $display("[TB] FAIL oob_resp%0d: got rvalid=%b rdata=%h oob=%b expected 1 %h %b", i, b1.rvalid, b1.rdata, b1.oob, want[31:0], want[32]);
            end
            @(negedge clk);
            n_checks++;
            if (b1.oob !== 1'b0 || b1.rvalid !== 1'b0) begin
                n_fail++; $display("[TB] FAIL oob_pulse%0d: got oob=%b rvalid=%b expected 0 0", i, b1.oob, b1.rvalid);
            end
        end
    endtask

    task automatic test_random1;
        logic [32:0] want;
        logic        w;
        logic [3:0]  be_v;
        logic [31:0] a;
        logic [31:0] d;
        int          k;
        for (int j = 0; j < 16; j++) begin
            d = $urandom;
            xfer1(1'b1, 4'hF, 32'h1000 + 32'(j * 4), d);
            void'(model1(1'b1, 4'hF, 32'h1000 + 32'(j * 4), d));
        end
        for (int i = 0; i < 30; i++) begin
            w = 1'($urandom_range(0, 1));
            be_v = 4'($urandom);
            d = $urandom;
            k = int'($urandom_range(0, 31)) - 8;
            a = 32'h1000 + 32'(k * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) a = $urandom;
            xfer1(w, be_v, a, d);
            want = model1(w, be_v, a, d);
            n_checks++;
            if (b1.rvalid !== 1'b1 || b1.rdata !== want[31:0] || b1.oob !== want[32]) begin
                n_fail++; $display("[TB] FAIL rnd1_resp%0d: addr=%h got rvalid=%b rdata=%h oob=%b expected 1 %h %b", i, a, b1.rvalid, b1.rdata, b1.oob, want[31:0], want[32]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enables();
        test_back_to_back();
        test_reset_mid();
        test_random0();
        test_wait_states();
        test_abort();
        test_out_of_range();
        test_random1();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "[TB] time limit");
    end

endmodule
